// File: rtl/btn_cond_if.sv
// Button-conditioning hand-off bundle: raw buttons and the enable/done move handshake.
// The sequencer/environment side uses the master modport; btn_cond uses the slave modport.
interface btn_cond_if;
    logic right_i;  // raw right button, asynchronous
    logic left_i;   // raw left button, asynchronous
    logic e_inp_i;  // hand-off request from the sequencer
    logic right_o;  // move-right flag of the current hand-off
    logic left_o;   // move-left flag of the current hand-off
    logic d_inp_o;  // hand-off done/valid

    modport master (
        output right_i, left_i, e_inp_i,
        input  right_o, left_o, d_inp_o
    );

    modport slave (
        input  right_i, left_i, e_inp_i,
        output right_o, left_o, d_inp_o
    );
endinterface

// File: rtl/btn_cond.sv
// btn_cond: synchronise and debounce the right/left buttons, latch presses as sticky pending
// events and hand exactly one move per enable/done hand-off to the sequencer.
// Optional feature: define BTN_COND_REPEAT_EN to build per-button auto-repeat.
// Button index 0 is right, index 1 is left throughout.
module btn_cond #(
    parameter int unsigned DB_CYC  = 4,
    parameter int unsigned RPT_DLY = 16,
    parameter int unsigned RPT_PER = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    btn_cond_if.slave bus_io
);

    localparam int unsigned CntW = $clog2(DB_CYC + 1);

    // Repeat period must be non-zero and no longer than the initial delay.
    if ((RPT_PER == 0) || (RPT_PER > RPT_DLY)) begin : g_bad_rpt_cfg
        $error("btn_cond: RPT_PER must lie in 1..RPT_DLY");
    end

    typedef enum logic [1:0] {StIdle, StCapt, StDone} state_e;

    logic [1:0]      s1_d, s1_q;
    logic [1:0]      s_d, s_q;
    logic [1:0]      db_d, db_q;
    logic [CntW-1:0] cnt_d [2];
    logic [CntW-1:0] cnt_q [2];
    logic [1:0]      rise;
    logic [1:0]      rpt;
    logic [1:0]      ev;
    logic [1:0]      pend_d, pend_q;
    logic            right_d, right_q;
    logic            left_d, left_q;
    state_e          state_d, state_q;
    logic            capt;
    logic            d_inp;

    // Two-stage synchroniser inputs.
    always_comb begin
        s1_d = {bus_io.left_i, bus_io.right_i};
        s_d  = s1_q;
    end

    // Debounce: count consecutive samples disagreeing with db, flip db on the DB_CYC-th one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            rise[i]  = 1'b0;
            if (s_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntW'(DB_CYC - 1)) begin
                    db_d[i] = ~db_q[i];
                    // Event fires alongside the flip so it lands with db going high.
                    rise[i] = ~db_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_COND_REPEAT_EN
    localparam int unsigned HoldW = $clog2(RPT_DLY + 1);

    logic [HoldW-1:0] hold_d [2];
    logic [HoldW-1:0] hold_q [2];

    // Hold counter: first repeat RPT_DLY cycles after the rise, then every RPT_PER cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hold_d[i] = '0;
            rpt[i]    = 1'b0;
            if (db_q[i]) begin
                if (hold_q[i] == HoldW'(RPT_DLY - 1)) begin
                    rpt[i]    = 1'b1;
                    hold_d[i] = HoldW'(RPT_DLY - RPT_PER);
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    // Hold counter state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q[0] <= '0;
            hold_q[1] <= '0;
        end else begin
            hold_q[0] <= hold_d[0];
            hold_q[1] <= hold_d[1];
        end
    end
`else
    // Without auto-repeat only db rising edges create events.
    always_comb begin
        rpt = 2'b00;
    end
`endif

    // Pending flags and move outputs; capture reloads pending with this cycle's events.
    always_comb begin
        ev      = rise | rpt;
        pend_d  = pend_q | ev;
        right_d = right_q;
        left_d  = left_q;
        if (capt) begin
            pend_d  = ev;
            right_d = pend_q[0] & ~pend_q[1];
            left_d  = pend_q[1] & ~pend_q[0];
        end
    end

    // Datapath state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s_q      <= '0;
            db_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            pend_q   <= '0;
            right_q  <= 1'b0;
            left_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s_q      <= s_d;
            db_q     <= db_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            pend_q   <= pend_d;
            right_q  <= right_d;
            left_q   <= left_d;
        end
    end

    // Hand-off FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Hand-off FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus_io.e_inp_i) state_d = StCapt;
            StCapt:  state_d = StDone;
            StDone:  if (!bus_io.e_inp_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Hand-off FSM outputs.
    always_comb begin
        capt  = (state_q == StCapt);
        d_inp = (state_q == StDone);
    end

    assign bus_io.right_o = right_q;
    assign bus_io.left_o  = left_q;
    assign bus_io.d_inp_o = d_inp;

endmodule
